// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM that sequences one instruction over
// several cycles through a single shared memory port, with a request watchdog and sticky traps.
module multicycle_controller #(
    parameter int MEM_TIMEOUT  = 16,
    parameter bit SUPPORT_JUMP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic [3:0] state_o,
    output logic       trap_illegal,
    output logic       trap_timeout
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UI       = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'd3;
    localparam logic [6:0] OP_STORE = 7'd35;
    localparam logic [6:0] OP_R     = 7'd51;
    localparam logic [6:0] OP_I     = 7'd19;
    localparam logic [6:0] OP_BR    = 7'd99;
    localparam logic [6:0] OP_JAL   = 7'd111;
    localparam logic [6:0] OP_JALR  = 7'd103;
    localparam logic [6:0] OP_LUI   = 7'd55;
    localparam logic [6:0] OP_AUIPC = 7'd23;

    // Counter holds MEM_TIMEOUT without wrapping; one bit is kept when the watchdog is off.
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : {CW{1'b0}};

    function automatic logic [2:0] imm_sel(input logic [6:0] o);
        case (o)
            OP_LOAD, OP_I, OP_JALR: imm_sel = 3'b000;
            OP_STORE:               imm_sel = 3'b010;
            OP_BR:                  imm_sel = 3'b011;
            OP_LUI, OP_AUIPC:       imm_sel = 3'b001;
            OP_JAL:                 imm_sel = 3'b100;
            default:                imm_sel = 3'b111;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                          input logic lt, input logic ltu);
        case (f3)
            3'b000:  branch_taken = z;
            3'b001:  branch_taken = ~z;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = ~lt;
            3'b110:  branch_taken = ltu;
            3'b111:  branch_taken = ~ltu;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    state_t        state_r;
    state_t        done_state_s;
    logic [CW-1:0] cnt_r;
    logic          trap_illegal_r;
    logic          trap_timeout_r;
    logic          timeout_s;

    logic       mem_req_s, adr_src_s, mem_write_s, ir_write_s, reg_write_s, pc_write_s;
    logic [1:0] alu_src_a_s, alu_src_b_s, alu_op_s, result_src_s;

    // The last permitted request cycle is the one where the count equals MEM_TIMEOUT-1.
    assign timeout_s = (MEM_TIMEOUT != 0) && (cnt_r == CNT_LAST);

    // Successor of each request state once its memory access completes.
    always_comb begin
        case (state_r)
            S_FETCH:   done_state_s = S_DECODE;
            S_MEMREAD: done_state_s = S_MEMWB;
            default:   done_state_s = S_FETCH;
        endcase
    end

    // State sequencing, request watchdog and sticky trap causes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= S_FETCH;
            cnt_r          <= {CW{1'b0}};
            trap_illegal_r <= 1'b0;
            trap_timeout_r <= 1'b0;
        end else begin
            cnt_r <= {CW{1'b0}};
            case (state_r)
                S_FETCH, S_MEMREAD, S_MEMWRITE: begin
                    if (mem_ready) begin
                        state_r <= done_state_s;
                    end else if (timeout_s) begin
                        state_r        <= S_TRAP;
                        trap_timeout_r <= 1'b1;
                    end else begin
                        cnt_r <= (MEM_TIMEOUT != 0) ? cnt_r + CW'(1) : {CW{1'b0}};
                    end
                end
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state_r <= S_MEMADR;
                        OP_R:              state_r <= S_EXECR;
                        OP_I:              state_r <= S_EXECI;
                        OP_BR: begin
                            // funct3 010/011 are not defined branch conditions
                            if (funct3[2:1] == 2'b01) begin
                                state_r        <= S_TRAP;
                                trap_illegal_r <= 1'b1;
                            end else begin
                                state_r <= S_BRANCH;
                            end
                        end
                        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
                            if (!SUPPORT_JUMP) begin
                                state_r        <= S_TRAP;
                                trap_illegal_r <= 1'b1;
                            end else if (op == OP_JAL) begin
                                state_r <= S_JAL;
                            end else if (op == OP_JALR) begin
                                state_r <= S_JALR;
                            end else begin
                                state_r <= S_UI;
                            end
                        end
                        default: begin
                            state_r        <= S_TRAP;
                            trap_illegal_r <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: state_r <= (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMWB:  state_r <= S_FETCH;
                S_EXECR:  state_r <= S_ALUWB;
                S_EXECI:  state_r <= S_ALUWB;
                S_ALUWB:  state_r <= S_FETCH;
                S_BRANCH: state_r <= S_FETCH;
                S_JALR:   state_r <= S_JAL;
                S_JAL:    state_r <= S_ALUWB;
                S_UI:     state_r <= S_ALUWB;
                S_TRAP:   state_r <= S_TRAP;
                default: begin
                    state_r        <= S_TRAP;
                    trap_illegal_r <= 1'b1;
                end
            endcase
        end
    end

    // Moore control decode; only the fetch strobes and branch PCWrite follow live inputs.
    always_comb begin
        mem_req_s    = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        pc_write_s   = 1'b0;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        result_src_s = 2'b00;
        case (state_r)
            S_FETCH: begin
                mem_req_s    = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = mem_ready;
                pc_write_s   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = 2'b10;
            end
            S_ALUWB: reg_write_s = 1'b1;
            S_BRANCH: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b01;
                pc_write_s  = branch_taken(funct3, alu_zero, alu_lt, alu_ltu);
            end
            S_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_write_s  = 1'b1;
            end
            S_JALR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
            S_UI: begin
                alu_src_b_s = 2'b01;
                if (op == OP_AUIPC) begin
                    alu_src_a_s = 2'b01;
                    alu_op_s    = 2'b00;
                end else begin
                    alu_op_s = 2'b11;
                end
            end
            default: begin
            end
        endcase
    end

    // Enables are killed combinationally so no write survives past the reset edge.
    assign mem_req   = mem_req_s & rst_n;
    assign MemWrite  = mem_write_s & rst_n;
    assign IRWrite   = ir_write_s & rst_n;
    assign RegWrite  = reg_write_s & rst_n;
    assign PCWrite   = pc_write_s & rst_n;
    assign AdrSrc    = adr_src_s;
    assign ALUSrcA   = alu_src_a_s;
    assign ALUSrcB   = alu_src_b_s;
    assign ALUOp     = alu_op_s;
    assign ResultSrc = result_src_s;
    assign ImmSrc    = imm_sel(op);
    assign state_o   = state_r;

    assign trap_illegal = trap_illegal_r;
    assign trap_timeout = trap_timeout_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench: two controller instances (watchdog 4 with jumps,
// watchdog off without jumps) checked every cycle against an instruction-path model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       alu_zero, alu_lt, alu_ltu, mem_ready;

    logic [16:0] ctl_v [2];
    logic [5:0]  st_v  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       mem_req, adr_src, mem_write, ir_write, reg_write, pc_write;
        logic [1:0] src_a, src_b, alu_op, res_src;
        logic [2:0] imm_src;
        logic [3:0] state;
        logic       t_ill, t_to;

        multicycle_controller #(
            .MEM_TIMEOUT ((g == 0) ? 4 : 0),
            .SUPPORT_JUMP((g == 0) ? 1'b1 : 1'b0)
        ) dut (
            .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
            .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
            .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(adr_src),
            .MemWrite(mem_write), .IRWrite(ir_write), .RegWrite(reg_write),
            .PCWrite(pc_write), .ALUSrcA(src_a), .ALUSrcB(src_b), .ALUOp(alu_op),
            .ResultSrc(res_src), .ImmSrc(imm_src), .state_o(state),
            .trap_illegal(t_ill), .trap_timeout(t_to)
        );

        assign ctl_v[g] = {mem_req, adr_src, mem_write, ir_write, reg_write, pc_write,
                           src_a, src_b, alu_op, res_src, imm_src};
        assign st_v[g]  = {state, t_ill, t_to};
    end

    typedef struct packed {
        logic [1:0][16:0] c;
        logic [1:0][5:0]  s;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Reference model: current state, pending state path of the instruction, wait count, flags.
    int m_st   [2];
    int m_wait [2];
    bit m_ill  [2];
    bit m_to   [2];
    int m_path [2][4];
    int m_plen [2];
    int m_pidx [2];

    function automatic int to_of(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    function automatic bit jmp_of(input int k);
        return (k == 0);
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] o);
        case (o)
            7'd3, 7'd19, 7'd103: return 3'b000;
            7'd35:               return 3'b010;
            7'd99:               return 3'b011;
            7'd55, 7'd23:        return 3'b001;
            7'd111:              return 3'b100;
            default:             return 3'b111;
        endcase
    endfunction

    function automatic logic exp_taken(input logic [2:0] f3);
        case (f3)
            3'd0:    return alu_zero;
            3'd1:    return !alu_zero;
            3'd4:    return alu_lt;
            3'd5:    return !alu_lt;
            3'd6:    return alu_ltu;
            3'd7:    return !alu_ltu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [16:0] exp_ctl(input int k, input bit in_rst);
        logic       req, adr, mw, irw, rw, pcw;
        logic [1:0] a, b, aop, res;
        {req, adr, mw, irw, rw, pcw} = 6'b0;
        {a, b, aop, res} = 8'b0;
        case (in_rst ? 0 : m_st[k])
            0:  begin req = 1'b1; b = 2'd2; res = 2'd2; irw = mem_ready; pcw = mem_ready; end
            1:  begin a = 2'd1; b = 2'd1; end
            2:  begin a = 2'd2; b = 2'd1; end
            3:  begin req = 1'b1; adr = 1'b1; end
            4:  begin res = 2'd1; rw = 1'b1; end
            5:  begin req = 1'b1; adr = 1'b1; mw = 1'b1; end
            6:  begin a = 2'd2; aop = 2'd2; end
            7:  begin a = 2'd2; b = 2'd1; aop = 2'd2; end
            8:  rw = 1'b1;
            9:  begin a = 2'd2; aop = 2'd1; pcw = exp_taken(funct3); end
            10: begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
            11: begin a = 2'd2; b = 2'd1; end
            12: begin b = 2'd1; if (op == 7'd55) aop = 2'd3; else a = 2'd1; end
            default: ;
        endcase
        if (in_rst) {req, mw, irw, rw, pcw} = 5'b0;
        return {req, adr, mw, irw, rw, pcw, a, b, aop, res, exp_imm(op)};
    endfunction

    task automatic model_reset(input int k);
        m_st[k] = 0; m_wait[k] = 0; m_ill[k] = 1'b0; m_to[k] = 1'b0;
        m_plen[k] = 0; m_pidx[k] = 0;
    endtask

    task automatic advance(input int k);
        if (m_pidx[k] < m_plen[k]) begin
            m_st[k] = m_path[k][m_pidx[k]];
            m_pidx[k]++;
        end else begin
            m_st[k] = 0;
        end
    endtask

    // Decide the remaining path of the instruction from its opcode.
    task automatic decode(input int k);
        int p [4];
        int n;
        bit legal;
        p = '{0, 0, 0, 0};
        n = 0;
        legal = 1'b1;
        case (op)
            7'd3:   begin p[0] = 2; p[1] = 3; p[2] = 4; n = 3; end
            7'd35:  begin p[0] = 2; p[1] = 5; n = 2; end
            7'd51:  begin p[0] = 6; p[1] = 8; n = 2; end
            7'd19:  begin p[0] = 7; p[1] = 8; n = 2; end
            7'd99:  begin p[0] = 9; n = 1; legal = (funct3 != 3'd2) && (funct3 != 3'd3); end
            7'd111: begin p[0] = 10; p[1] = 8; n = 2; legal = jmp_of(k); end
            7'd103: begin p[0] = 11; p[1] = 10; p[2] = 8; n = 3; legal = jmp_of(k); end
            7'd55, 7'd23: begin p[0] = 12; p[1] = 8; n = 2; legal = jmp_of(k); end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            m_st[k] = 13;
            m_ill[k] = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) m_path[k][i] = p[i];
            m_plen[k] = n;
            m_pidx[k] = 0;
            advance(k);
        end
    endtask

    task automatic model_step(input int k);
        case (m_st[k])
            0, 3, 5: begin
                if (mem_ready) begin
                    m_wait[k] = 0;
                    if (m_st[k] == 0) m_st[k] = 1;
                    else advance(k);
                end else begin
                    m_wait[k]++;
                    if (to_of(k) > 0 && m_wait[k] == to_of(k)) begin
                        m_st[k] = 13;
                        m_to[k] = 1'b1;
                    end
                end
            end
            1:  decode(k);
            13: ;
            default: advance(k);
        endcase
    endtask

    function automatic logic [6:0] pick_op();
        logic [6:0] tbl [9];
        int r;
        tbl = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111, 7'd103, 7'd55, 7'd23};
        r = $urandom_range(0, 19);
        if (r < 18) return tbl[r / 2];
        if (r == 18) return 7'h7F;
        return 7'($urandom_range(0, 127));
    endfunction

    // Monitor: compare each presented cycle against the queued expectation.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (ctl_v[k] !== mon_e.c[k]) begin
                    errors++;
                    $display("FAIL ctl dut%0d cycle %0d: got %05h expected %05h",
                             k, mon_e.cyc, ctl_v[k], mon_e.c[k]);
                end
                checks++;
                if (st_v[k] !== mon_e.s[k]) begin
                    errors++;
                    $display("FAIL state/trap dut%0d cycle %0d: got %02h expected %02h",
                             k, mon_e.cyc, st_v[k], mon_e.s[k]);
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   rst_hold;
        int   stall;
        rst_hold = 3;
        stall    = 0;
        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) model_reset(k);

        for (int n = 0; n < 20000; n++) begin
            @(posedge clk);
            #1;
            if (rst_hold > 0) begin
                rst_n = 1'b0;
                rst_hold--;
            end else if ((m_st[0] == 13 && m_st[1] == 13 && $urandom_range(0, 3) == 0) ||
                         (m_st[0] == 5 && $urandom_range(0, 19) == 0) ||
                         ($urandom_range(0, 59) == 0)) begin
                rst_n = 1'b0;
                rst_hold = $urandom_range(0, 2);
            end else begin
                rst_n = 1'b1;
            end

            alu_zero = 1'($urandom_range(0, 1));
            alu_lt   = 1'($urandom_range(0, 1));
            alu_ltu  = 1'($urandom_range(0, 1));

            // Ready mostly, with stall bursts long enough to reach the watchdog limit.
            if (stall > 0) begin
                mem_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 9) < 6) begin
                mem_ready = 1'b1;
            end else begin
                mem_ready = 1'b0;
                stall = $urandom_range(0, 5);
            end

            // The instruction register only changes while no instance is mid-instruction.
            if ((m_st[0] == 0 || m_st[0] == 13) && (m_st[1] == 0 || m_st[1] == 13)) begin
                op     = pick_op();
                funct3 = 3'($urandom_range(0, 7));
            end

            if (!rst_n) begin
                for (int k = 0; k < 2; k++) model_reset(k);
            end
            for (int k = 0; k < 2; k++) begin
                e.c[k] = exp_ctl(k, !rst_n);
                e.s[k] = {4'(m_st[k]), m_ill[k], m_to[k]};
            end
            e.cyc = n;
            sb.push_back(e);
            if (rst_n) begin
                for (int k = 0; k < 2; k++) model_step(k);
            end
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle RISC-V control unit: a Moore FSM that sequences one RV32I instruction over several cycles using a single shared memory port. It sits between the instruction register and the shared ALU/register-file datapath. It generalises the single-cycle main decoder with three additions: a variable-latency memory handshake, a watchdog timeout, and full branch/jump/upper-immediate coverage. Illegal opcodes and memory timeouts trap rather than only printing a message.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum request cycles without mem_ready before trapping; 0 disables the watchdog.
- SUPPORT_JUMP, 1: when 0, jal (111), jalr (103), lui (55) and auipc (23) are illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- alu_zero, alu_lt, alu_ltu  in  1 each  ALU flags: equal, signed less-than, unsigned less-than.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- AdrSrc  out  1  address select: 0 = PC, 1 = ALUOut.
- MemWrite, IRWrite, RegWrite, PCWrite  out  1 each  write enables.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- ALUOp  out  2  00 = add, 01 = compare/sub, 10 = funct-decoded, 11 = pass B.
- ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALUResult.
- ImmSrc  out  3  combinational from op in every state: I = 000 (op 3/19/103), S = 010, B = 011, U = 001, J = 100, otherwise 111.
- state_o  out  4  current state encoding.
- trap_illegal, trap_timeout  out  1 each  sticky trap causes.

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, UI 12, TRAP 13. Encodings 14–15 go to TRAP with trap_illegal = 1.
- Defaults: all enables 0, selects 00.
- FETCH: mem_req = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ResultSrc = 10. IRWrite and PCWrite equal mem_ready. Stay until mem_ready, then go to DECODE.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, computing the branch/jal/auipc target into ALUOut. Next state by op:
  - 3 or 35 → MEMADR.
  - 51 → EXECR.
  - 19 → EXECI.
  - 99 → BRANCH; illegal if funct3 is 010 or 011.
  - 111 → JAL.
  - 103 → JALR.
  - 55 or 23 → UI.
  - Anything else → TRAP with trap_illegal = 1.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01. Next: MEMREAD for op 3, MEMWRITE for op 35.
- MEMREAD: mem_req = 1, AdrSrc = 1. Wait for mem_ready, then MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, then FETCH.
- MEMWRITE: mem_req = 1, AdrSrc = 1, MemWrite = 1. Wait for mem_ready, then FETCH.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10, then ALUWB.
- EXECI: same as EXECR but ALUSrcB = 01, then ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, then FETCH.
- BRANCH: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00. PCWrite = taken, then FETCH. Taken by funct3:
  - 000: zero.
  - 001: !zero.
  - 100: lt.
  - 101: !lt.
  - 110: ltu.
  - 111: !ltu.
- JALR: ALUSrcA = 10, ALUSrcB = 01, placing the target in ALUOut, then JAL.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 00, PCWrite = 1, then ALUWB (writes OldPC + 4).
- UI: ALUSrcB = 01. lui uses ALUOp = 11; auipc uses ALUSrcA = 01, ALUOp = 00. Then ALUWB.
- TRAP: all enables 0. Stays in TRAP until reset. The trap flags are sticky.

## Timing
- Reset is asynchronous. While rst_n = 0 and on release:
  - state = FETCH, watchdog count = 0, trap flags = 0.
  - All enables (mem_req, IRWrite, PCWrite, RegWrite, MemWrite) forced to 0 while rst_n = 0.
  - Selects take their FETCH values.
- Reset asserted mid-instruction drops all enables in the same cycle. No partial write completes after the reset edge.
- Latency with mem_ready tied high:
  - Loads: 5 cycles.
  - Stores: 4 cycles.
  - R-type, I-type ALU, lui, auipc: 4 cycles.
  - Branches: 3 cycles.
  - jal: 4 cycles.
  - jalr: 5 cycles.
  - Each wait cycle adds 1.
- Handshake: mem_req stays high and address/MemWrite stay stable until the cycle mem_ready = 1. The access completes in that cycle. mem_ready outside a request state is ignored.
- Watchdog: the count resets on entry to each request state and increments on each request cycle with mem_ready = 0.
  - If request cycle number MEM_TIMEOUT also has mem_ready = 0, the next state is TRAP with trap_timeout = 1.
  - mem_ready on cycle MEM_TIMEOUT is accepted normally.
  - The counter is wide enough to hold MEM_TIMEOUT (clog2(MEM_TIMEOUT + 1) bits), so it never wraps.

## Test plan
- Reset, then lw (op 3) with mem_ready = 1 → state_o sequence 0, 1, 2, 3, 4, 0; RegWrite high only in state 4; IRWrite pulses once in state 0.
- Fetch with mem_ready rising on the 3rd request cycle → state 0 held 3 cycles; IRWrite = PCWrite = 1 only on the 3rd cycle.
- bne (op 99, funct3 001) → with alu_zero = 1, PCWrite = 0 in state 9; with alu_zero = 0, PCWrite = 1; next state 0.
- MEM_TIMEOUT = 4, mem_ready never asserted in MEMWRITE → state 13 after 4 request cycles, trap_timeout = 1, MemWrite = 0 thereafter. In a second run with mem_ready on the 4th cycle → state 0, no trap.
- op 7'h7F → state 13, trap_illegal = 1. With SUPPORT_JUMP = 0, op 111 → state 13. Both flags hold until rst_n = 0.
- rst_n low during MEMWRITE with mem_req = 1 → mem_req and MemWrite drop to 0 immediately; after release, state_o = 0.
